// File: rtl/timer_pkg.sv
// Shared types and helpers for the round countdown timer: state encoding,
// BCD arithmetic and nibble clamping.
package timer_pkg;

    localparam int DEFAULT_TICKS_PER_SEC = 50000000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        PAUSED  = 3'd2,
        EXPIRED = 3'd3,
        ARMED   = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Two-digit BCD decrement; callers never pass 8'h00.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    function automatic logic [3:0] clamp_nibble(input logic [3:0] n);
        return (n > 4'd9) ? 4'd9 : n;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second tick divider. Holds its count while disabled so a paused
// countdown resumes mid-second; Clear restarts the second.
module tick_gen
    import timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Clear,
    input  logic En,
    output logic Tick
);

    localparam int W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [W-1:0] LAST = W'(TICKS_PER_SEC - 1);

    logic [W-1:0] div_q;

    assign Tick = En && (div_q == LAST);

    always_ff @(posedge Clock) begin
        if (Reset || Clear) begin
            div_q <= '0;
        end else if (En) begin
            div_q <= Tick ? '0 : div_q + 1'b1;
        end
    end

endmodule

// File: rtl/round_timer_ctrl.sv
// Round sequencer for the game countdown: loads a BCD round length, counts
// down once per second, and tracks round number, expiry and game over.
module round_timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC,
    parameter int NUM_ROUNDS    = 3
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Pause,
    input  logic       Stop,
    input  logic [7:0] RoundLen,
    output logic [7:0] SecondsBCD,
    output logic [3:0] Round,
    output logic [2:0] State,
    output logic       Running,
    output logic       Expired,
    output logic       GameOver
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t     state_q, state_d;
    logic [7:0] secs_q, secs_d;
    logic [3:0] round_q, round_d;
    logic       clear;
    logic       tick;
    logic       do_load;
    logic       do_abort;
    logic [3:0] load_round;
    logic [7:0] load_secs;
    logic [3:0] round_inc;

    tick_gen #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick_gen (
        .Clock (Clock),
        .Reset (Reset),
        .Clear (clear),
        .En    (state_q == RUN),
        .Tick  (tick)
    );

    assign load_secs = {clamp_nibble(RoundLen[7:4]), clamp_nibble(RoundLen[3:0])};
    assign round_inc = (round_q == 4'd15) ? 4'd15 : round_q + 4'd1;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            secs_q  <= 8'h00;
            round_q <= 4'd0;
        end else begin
            state_q <= state_d;
            secs_q  <= secs_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        secs_d     = secs_q;
        round_d    = round_q;
        clear      = 1'b0;
        do_load    = 1'b0;
        do_abort   = 1'b0;
        load_round = 4'd1;

        case (state_q)
            IDLE: begin
                if (Stop)       do_abort = 1'b1;
                else if (Start) do_load  = 1'b1;
            end
            DONE: begin
                if (Stop)       do_abort = 1'b1;
                else if (Start) do_load  = 1'b1;
            end
            ARMED: begin
                if (Stop) begin
                    do_abort = 1'b1;
                end else if (Start) begin
                    do_load    = 1'b1;
                    load_round = round_inc;
                end
            end
            RUN: begin
                if (Stop) begin
                    do_abort = 1'b1;
                end else begin
                    // A tick coinciding with Pause still decrements; reaching
                    // zero overrides the pause.
                    if (tick) secs_d = bcd_dec(secs_q);
                    if (tick && secs_q == 8'h01) state_d = EXPIRED;
                    else if (Pause)              state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (Stop)       do_abort = 1'b1;
                else if (Pause) state_d  = RUN;
            end
            EXPIRED: begin
                state_d = (round_q == LAST_ROUND) ? DONE : ARMED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_abort) begin
            state_d = IDLE;
            secs_d  = 8'h00;
            round_d = 4'd0;
            clear   = 1'b1;
        end else if (do_load) begin
            secs_d  = load_secs;
            round_d = load_round;
            clear   = 1'b1;
            state_d = (load_secs == 8'h00) ? EXPIRED : RUN;
        end
    end

    assign SecondsBCD = secs_q;
    assign Round      = round_q;
    assign State      = state_q;
    assign Running    = (state_q == RUN);
    assign Expired    = (state_q == EXPIRED);
    assign GameOver   = (state_q == DONE);

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Directed bench for round_timer_ctrl with TICKS_PER_SEC=4, NUM_ROUNDS=2:
// the driver queues expected snapshots and expiry rounds, a monitor checks them.
module tb_round_timer_ctrl;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RUN     = 3'd1;
    localparam logic [2:0] S_PAUSED  = 3'd2;
    localparam logic [2:0] S_EXPIRED = 3'd3;
    localparam logic [2:0] S_ARMED   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic       Clock;
    logic       Reset;
    logic       Start;
    logic       Pause;
    logic       Stop;
    logic [7:0] RoundLen;
    logic [7:0] SecondsBCD;
    logic [3:0] Round;
    logic [2:0] State;
    logic       Running;
    logic       Expired;
    logic       GameOver;

    int checks = 0;
    int errors = 0;

    // Snapshot: {state[2:0], round[3:0], secs[7:0], running, expired, gameover}
    logic [17:0] exp_q[$];
    string       name_q[$];
    logic [3:0]  exp_round_q[$];

    round_timer_ctrl #(.TICKS_PER_SEC(4), .NUM_ROUNDS(2)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .Pause      (Pause),
        .Stop       (Stop),
        .RoundLen   (RoundLen),
        .SecondsBCD (SecondsBCD),
        .Round      (Round),
        .State      (State),
        .Running    (Running),
        .Expired    (Expired),
        .GameOver   (GameOver)
    );

    // Clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Driver tasks
    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(posedge Clock);
        #1;
    endtask

    task automatic pulse(input int which);
        if (which == 0) Start = 1'b1;
        if (which == 1) Pause = 1'b1;
        if (which == 2) Stop  = 1'b1;
        step(1);
        Start = 1'b0;
        Pause = 1'b0;
        Stop  = 1'b0;
    endtask

    task automatic expect_snap(input string nm, input logic [2:0] st,
                               input logic [3:0] rd, input logic [7:0] s);
        exp_q.push_back({st, rd, s, st == S_RUN, st == S_EXPIRED, st == S_DONE});
        name_q.push_back(nm);
    endtask

    // Monitor / scoreboard
    always @(negedge Clock) begin
        logic [17:0] act, exp_v;
        string       nm;
        logic [3:0]  er;
        act = {State, Round, SecondsBCD, Running, Expired, GameOver};
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL %s: got st=%0d rd=%0d sec=%h run/exp/go=%b, expected st=%0d rd=%0d sec=%h run/exp/go=%b",
                         nm, act[17:15], act[14:11], act[10:3], act[2:0],
                         exp_v[17:15], exp_v[14:11], exp_v[10:3], exp_v[2:0]);
            end
        end
        if (Expired === 1'b1) begin
            checks++;
            if (exp_round_q.size() == 0) begin
                errors++;
                $display("FAIL expiry_unexpected: got Expired=1 in round %0d, expected no expiry", Round);
            end else begin
                er = exp_round_q.pop_front();
                if (Round !== er) begin
                    errors++;
                    $display("FAIL expiry_round: got %0d, expected %0d", Round, er);
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        Reset    = 1'b1;
        Start    = 1'b0;
        Pause    = 1'b0;
        Stop     = 1'b0;
        RoundLen = 8'h00;
        step(2);
        Reset = 1'b0;
        expect_snap("reset", S_IDLE, 4'd0, 8'h00);
        pulse(1);
        expect_snap("pause_idle", S_IDLE, 4'd0, 8'h00);

        // Round 1: three seconds
        RoundLen = 8'h03;
        exp_round_q.push_back(4'd1);
        pulse(0);
        expect_snap("run_entry", S_RUN, 4'd1, 8'h03);
        step(3); expect_snap("hold_03", S_RUN, 4'd1, 8'h03);
        step(1); expect_snap("tick_02", S_RUN, 4'd1, 8'h02);
        step(4); expect_snap("tick_01", S_RUN, 4'd1, 8'h01);
        step(4); expect_snap("expired_r1", S_EXPIRED, 4'd1, 8'h00);
        step(1); expect_snap("armed_r1", S_ARMED, 4'd1, 8'h00);

        // Round 2: BCD borrow, pause/resume mid-second, Start ignored
        RoundLen = 8'h10;
        pulse(0);
        expect_snap("run_r2", S_RUN, 4'd2, 8'h10);
        step(4); expect_snap("borrow_09", S_RUN, 4'd2, 8'h09);
        step(4); expect_snap("tick_08", S_RUN, 4'd2, 8'h08);
        step(1);
        pulse(1); expect_snap("paused", S_PAUSED, 4'd2, 8'h08);
        step(20); expect_snap("hold_paused", S_PAUSED, 4'd2, 8'h08);
        pulse(1); expect_snap("resume", S_RUN, 4'd2, 8'h08);
        step(1); expect_snap("resume_hold", S_RUN, 4'd2, 8'h08);
        step(1); expect_snap("resume_tick", S_RUN, 4'd2, 8'h07);
        exp_round_q.push_back(4'd2);
        pulse(0); expect_snap("start_ignored", S_RUN, 4'd2, 8'h07);
        step(27); expect_snap("expired_r2", S_EXPIRED, 4'd2, 8'h00);
        step(1); expect_snap("game_over", S_DONE, 4'd2, 8'h00);
        pulse(1); expect_snap("pause_done", S_DONE, 4'd2, 8'h00);

        // Restart from DONE, then Stop
        RoundLen = 8'h02;
        pulse(0); expect_snap("restart", S_RUN, 4'd1, 8'h02);
        step(2); expect_snap("pre_stop", S_RUN, 4'd1, 8'h02);
        pulse(2); expect_snap("stop", S_IDLE, 4'd0, 8'h00);

        // Clamp, then Reset mid-run
        RoundLen = 8'hAF;
        pulse(0); expect_snap("clamp", S_RUN, 4'd1, 8'h99);
        step(2);
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
        expect_snap("reset_mid", S_IDLE, 4'd0, 8'h00);

        // Zero-length rounds
        RoundLen = 8'h00;
        exp_round_q.push_back(4'd1);
        pulse(0); expect_snap("zero_load", S_EXPIRED, 4'd1, 8'h00);
        step(1); expect_snap("zero_armed", S_ARMED, 4'd1, 8'h00);
        exp_round_q.push_back(4'd2);
        pulse(0); expect_snap("zero_r2", S_EXPIRED, 4'd2, 8'h00);
        step(1); expect_snap("zero_done", S_DONE, 4'd2, 8'h00);

        // Pause on the tick that reaches zero: expiry wins
        RoundLen = 8'h01;
        exp_round_q.push_back(4'd1);
        pulse(0); expect_snap("run_01", S_RUN, 4'd1, 8'h01);
        step(3);
        pulse(1); expect_snap("pause_tick_exp", S_EXPIRED, 4'd1, 8'h00);
        step(1); expect_snap("armed_after", S_ARMED, 4'd1, 8'h00);

        // Pause on a non-final tick: decrement applied, then paused
        RoundLen = 8'h02;
        pulse(0); expect_snap("run_r2b", S_RUN, 4'd2, 8'h02);
        step(3);
        pulse(1); expect_snap("pause_tick", S_PAUSED, 4'd2, 8'h01);
        pulse(2); expect_snap("stop_paused", S_IDLE, 4'd0, 8'h00);

        step(3);
        checks++;
        if (exp_round_q.size() != 0) begin
            errors++;
            $display("FAIL missing_expiry: got %0d expiries outstanding, expected 0", exp_round_q.size());
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL unchecked_snapshots: got %0d outstanding, expected 0", exp_q.size());
        end

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
